bias_bank: RTL
==============

BIAS_BANK -- requirements
Module: bias_bank

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the signed fixed-point data/bias width per lane.
REQ-002 The module SHALL have parameter LANES, default 4, giving the number of systolic-array columns served (LANES >= 1).
REQ-003 The module SHALL have parameter GRAD_WIDTH, default 24, giving the signed gradient accumulator width (GRAD_WIDTH >= WIDTH).
REQ-004 The module SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 The module SHALL have port bias_load_in  in  1  shifts one bias word into the inactive bank.
REQ-007 The module SHALL have port bias_scalar_in  in  WIDTH  bias word to load.
REQ-008 The module SHALL have port bias_scalar_out  out  WIDTH  registered cascade output to the next bias_bank.
REQ-009 The module SHALL have port bias_switch_in  in  1  request to copy the inactive bank into the active bank.
REQ-010 The module SHALL have port bias_loaded_out  out  1  high when the inactive bank holds LANES fresh words.
REQ-011 The module SHALL have port bias_mode_in  in  1  0 = forward (add bias), 1 = backward (pass-through plus gradient accumulation).
REQ-012 The module SHALL have port bias_valid_in  in  LANES  per-lane valid from the array (lanes are staggered).
REQ-013 The module SHALL have port bias_data_in  in  LANES*WIDTH  per-lane signed data, lane i at bits [i*WIDTH +: WIDTH].
REQ-014 The module SHALL have port bias_valid_out  out  LANES  per-lane valid, delayed by one cycle.
REQ-015 The module SHALL have port bias_data_out  out  LANES*WIDTH  per-lane result.
REQ-016 The module SHALL have port grad_clear_in  in  1  starts a new gradient batch.
REQ-017 The module SHALL have port grad_out  out  LANES*GRAD_WIDTH  per-lane accumulated bias gradient.

Function
REQ-018 On bias_load_in, inactive[0] SHALL take bias_scalar_in, inactive[i] SHALL take inactive[i-1], and bias_scalar_out SHALL take the old inactive[LANES-1]; the word loaded first therefore ends in lane LANES-1.
REQ-019 The load FSM SHALL have states EMPTY, FILLING and FULL, tracked by a count of 0..LANES.
- EMPTY -> FILLING on the first load.
- FILLING -> FULL when the count reaches LANES.
- Further loads in FULL SHALL keep shifting and keep the state FULL.
REQ-020 bias_loaded_out SHALL be 1 exactly in state FULL.
REQ-021 bias_switch_in while FULL SHALL copy all inactive words to active at that edge and SHALL set the state to EMPTY.
REQ-022 bias_switch_in while not FULL SHALL be ignored: the active bank, the inactive bank and the count stay unchanged.
REQ-023 When switch and load coincide while FULL, active SHALL take the pre-shift inactive values, the shift SHALL still occur, and the state SHALL become FILLING with count 1.
REQ-024 Forward mode, lane i with valid_in[i]=1: data_out[i] SHALL be data_in[i] + active[i], saturated to the signed WIDTH range, after 1 cycle.
REQ-025 Backward mode, lane i with valid_in[i]=1:
- data_out[i] SHALL be data_in[i] unchanged, after 1 cycle.
- grad[i] SHALL be grad[i] + sign-extended data_in[i], saturated to the signed GRAD_WIDTH range.
REQ-026 For any lane with valid_in[i]=0, data_out[i] and grad[i] SHALL hold their values.
REQ-027 valid_out[i] SHALL equal valid_in[i] delayed by one cycle, regardless of mode.
REQ-028 grad_clear_in SHALL zero all grad lanes; a lane accumulating in the same cycle SHALL be set to sign-extended data_in[i] instead.
REQ-029 A change of bias_mode_in SHALL take effect in the same cycle, with no bubble.
REQ-030 The active bank SHALL change only via REQ-021 and REQ-023, never combinationally.

Reset
REQ-031 While rst=0, the following SHALL all be 0: active bank, inactive bank, count/state (EMPTY), bias_scalar_out, bias_loaded_out, bias_valid_out, bias_data_out and grad_out.
REQ-032 Reset asserted mid-operation SHALL take effect immediately, without a clock edge.
REQ-033 After rst is released, the first rising edge SHALL operate normally.

Verification (WIDTH=16, LANES=4, GRAD_WIDTH=24)
REQ-034 The bench SHALL cover load then switch:
- Stimulus: load 0x0004, 0x0003, 0x0002, 0x0001, then switch.
- Required: loaded_out=1 after the 4th load and 0 after the switch.
- Required: forward inputs of 0x0010 on all lanes give lanes 0..3 = 0x0011, 0x0012, 0x0013, 0x0014.
REQ-035 The bench SHALL cover premature switch:
- Stimulus: 2 loads, then switch.
- Required: active stays 0 and forward 0x0005 returns 0x0005.
REQ-036 The bench SHALL cover saturation:
- Stimulus: active=0x7000, forward input 0x2000.
- Required: output 0x7FFF.
- Stimulus: active=0x8000, forward input 0xF000.
- Required: output 0x8000.
REQ-037 The bench SHALL cover backward accumulation:
- Stimulus: lane 2 receives 0x0100, 0xFF00, 0x0300 in backward mode.
- Required: outputs equal the inputs 1 cycle later and grad[2]=0x000300.
- Stimulus: grad_clear_in with input 0x0005 in the same cycle.
- Required: grad[2]=0x000005.
REQ-038 The bench SHALL cover staggered valid and cascade:
- Stimulus: valid_in 0001, 0011, 0111, 1111 on consecutive cycles.
- Required: valid_out mirrors it 1 cycle late, and idle lanes hold data_out.
- Required: bias_scalar_out emits the first-loaded word on the 5th load.
REQ-039 The bench SHALL cover reset mid-fill:
- Stimulus: assert rst=0 asynchronously between edges after 3 loads.
- Required: all outputs 0 immediately and loaded_out=0.
- Required: after release, 4 new loads are needed before a switch is honoured.

Source files
------------

// File: rtl/bias_bank.sv
// Double-buffered per-lane bias bank for a systolic array: adds bias in forward
// mode, passes data through and accumulates bias gradients in backward mode.
module bias_bank #(
    parameter int WIDTH      = 16,
    parameter int LANES      = 4,
    parameter int GRAD_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bias_load_in,
    input  logic [WIDTH-1:0]              bias_scalar_in,
    output logic [WIDTH-1:0]              bias_scalar_out,
    input  logic                          bias_switch_in,
    output logic                          bias_loaded_out,
    input  logic                          bias_mode_in,
    input  logic [LANES-1:0]              bias_valid_in,
    input  logic [LANES*WIDTH-1:0]        bias_data_in,
    output logic [LANES-1:0]              bias_valid_out,
    output logic [LANES*WIDTH-1:0]        bias_data_out,
    input  logic                          grad_clear_in,
    output logic [LANES*GRAD_WIDTH-1:0]   grad_out
);

    localparam int CW = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } load_state_e;

    load_state_e                          state_q, state_d;
    logic [CW-1:0]                        count_q, count_d;
    logic [LANES-1:0][WIDTH-1:0]          inactive_q, inactive_d;
    logic [LANES-1:0][WIDTH-1:0]          active_q, active_d;
    logic [WIDTH-1:0]                     scalar_out_q, scalar_out_d;
    logic [LANES-1:0]                     valid_out_q, valid_out_d;
    logic [LANES-1:0][WIDTH-1:0]          data_out_q, data_out_d;
    logic [LANES-1:0][GRAD_WIDTH-1:0]     grad_q, grad_d;

    logic [WIDTH-1:0]                     lane_data;
    logic [GRAD_WIDTH-1:0]                lane_ext;
    logic                                 lane_accum;

    // Overflow iff the extra sign bit disagrees with the result's sign bit.
    function automatic logic [WIDTH-1:0] sat_add_data(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (s[WIDTH] != s[WIDTH-1])
            return {s[WIDTH], {(WIDTH-1){~s[WIDTH]}}};
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [GRAD_WIDTH-1:0] sat_add_grad(input logic [GRAD_WIDTH-1:0] a,
                                                           input logic [GRAD_WIDTH-1:0] b);
        logic [GRAD_WIDTH:0] s;
        s = {a[GRAD_WIDTH-1], a} + {b[GRAD_WIDTH-1], b};
        if (s[GRAD_WIDTH] != s[GRAD_WIDTH-1])
            return {s[GRAD_WIDTH], {(GRAD_WIDTH-1){~s[GRAD_WIDTH]}}};
        return s[GRAD_WIDTH-1:0];
    endfunction

    function automatic logic [GRAD_WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
        logic signed [GRAD_WIDTH-1:0] r;
        r = GRAD_WIDTH'($signed(v));
        return r;
    endfunction

    // Bank control: a switch consumes the full bank first, so a coincident load
    // lands in the now-empty inactive bank as its first word.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        count_d      = count_q;
        inactive_d   = inactive_q;
        active_d     = active_q;
        scalar_out_d = scalar_out_q;

        if (bias_switch_in && state_q == FULL) begin
            active_d = inactive_q;
            count_d  = '0;
            state_d  = EMPTY;
        end

        if (bias_load_in) begin
            inactive_d[0] = bias_scalar_in;
            for (int i = 1; i < LANES; i++)
                inactive_d[i] = inactive_q[i-1];
            scalar_out_d = inactive_q[LANES-1];
            if (count_d != CW'(LANES))
                count_d = count_d + CW'(1);
            state_d = (count_d == CW'(LANES)) ? FULL : FILLING;
        end
    end

    always_comb begin
        valid_out_d = bias_valid_in;
        data_out_d  = data_out_q;
        grad_d      = grad_q;
        lane_data   = '0;
        lane_ext    = '0;
        lane_accum  = 1'b0;

        for (int i = 0; i < LANES; i++) begin
            lane_data  = bias_data_in[i*WIDTH +: WIDTH];
            lane_ext   = sext(lane_data);
            lane_accum = bias_valid_in[i] && bias_mode_in;

            if (bias_valid_in[i])
                data_out_d[i] = bias_mode_in ? lane_data : sat_add_data(lane_data, active_q[i]);

            // Clear starts a new batch; an accumulating lane seeds it with its sample.
            if (grad_clear_in)
                grad_d[i] = lane_accum ? lane_ext : '0;
            else if (lane_accum)
                grad_d[i] = sat_add_grad(grad_q[i], lane_ext);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            count_q      <= '0;
            inactive_q   <= '0;
            active_q     <= '0;
            scalar_out_q <= '0;
            valid_out_q  <= '0;
            data_out_q   <= '0;
            grad_q       <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            inactive_q   <= inactive_d;
            active_q     <= active_d;
            scalar_out_q <= scalar_out_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            grad_q       <= grad_d;
        end
    end

    assign bias_scalar_out = scalar_out_q;
    assign bias_loaded_out = (state_q == FULL);
    assign bias_valid_out  = valid_out_q;
    assign bias_data_out   = data_out_q;
    assign grad_out        = grad_q;

endmodule
